// File: rtl/fb_pkg.sv
// Shared framebuffer types and constants.
// Holds the framebuffer geometry, the address and pixel types, the fill
// state machine encoding, the requester identifiers used by the arbiter,
// and a helper that turns a pixel count into the final fill address.
package fb_pkg;

    localparam int unsigned FB_WIDTH   = 32'd320;
    localparam int unsigned FB_HEIGHT  = 32'd240;
    localparam int unsigned FB_SIZE    = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned ADDR_WIDTH = 32'd17;
    localparam int unsigned DATA_WIDTH = 32'd8;

    typedef logic [ADDR_WIDTH-1:0] fb_addr_t;
    typedef logic [DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_SCAN = 2'd1,
        REQ_CPU  = 2'd2,
        REQ_FILL = 2'd3
    } requester_t;

    // Address written by the final grant of a fill covering 'count' pixels.
    function automatic fb_addr_t last_fill_addr(input int unsigned count);
        last_fill_addr = fb_addr_t'(count - 32'd1);
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus.
// Bundles the three requester ports (scan-out read, CPU write, fill
// control) and the single RAM port. The 'slave' modport is the arbiter's
// view; 'master' is the view of everything around it (requesters + RAM).
//   scan_req/scan_address -> scan_grant, scan_valid, scan_data
//   wr_req/wr_address/wr_data -> wr_grant
//   fill_start/fill_color -> fill_busy, fill_done
//   mem_address/mem_write/mem_write_data -> RAM, mem_read_data <- RAM
interface fb_arbiter_if;
    import fb_pkg::*;

    logic     scan_req;
    fb_addr_t scan_address;
    logic     scan_grant;
    logic     scan_valid;
    pixel_t   scan_data;

    logic     wr_req;
    fb_addr_t wr_address;
    pixel_t   wr_data;
    logic     wr_grant;

    logic     fill_start;
    pixel_t   fill_color;
    logic     fill_busy;
    logic     fill_done;

    fb_addr_t mem_address;
    logic     mem_write;
    pixel_t   mem_write_data;
    pixel_t   mem_read_data;

    modport slave (
        input  scan_req, scan_address, wr_req, wr_address, wr_data,
               fill_start, fill_color, mem_read_data,
        output scan_grant, scan_valid, scan_data, wr_grant,
               fill_busy, fill_done, mem_address, mem_write, mem_write_data
    );

    modport master (
        output scan_req, scan_address, wr_req, wr_address, wr_data,
               fill_start, fill_color, mem_read_data,
        input  scan_grant, scan_valid, scan_data, wr_grant,
               fill_busy, fill_done, mem_address, mem_write, mem_write_data
    );

endinterface

// File: rtl/fb_fill_engine.sv
// Clear-screen fill engine.
// Walks addresses 0..FILL_COUNT-1, one pixel per grant, writing a colour
// latched when the fill was started.
//   clk, rst      : clock, synchronous active-high reset
//   fill_start    : start pulse (ignored while busy)
//   fill_color    : colour sampled with an accepted start
//   fill_grant    : arbiter accepted the pending fill write this cycle
//   fill_pending  : a fill write is waiting for a grant
//   fill_addr     : address of the pending fill write
//   fill_data     : colour of the pending fill write
//   fill_busy     : high while filling and during the done cycle
//   fill_done     : one-cycle pulse after the last fill write is granted
module fb_fill_engine
    import fb_pkg::*;
#(
    parameter int unsigned FILL_COUNT = FB_SIZE
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     fill_start,
    input  pixel_t   fill_color,
    input  logic     fill_grant,
    output logic     fill_pending,
    output fb_addr_t fill_addr,
    output pixel_t   fill_data,
    output logic     fill_busy,
    output logic     fill_done
);

    localparam fb_addr_t LAST_ADDR = last_fill_addr(FILL_COUNT);

    fill_state_t state_r;
    fb_addr_t    count_r;
    pixel_t      color_r;
    logic        busy_r;
    logic        done_r;

    // Fill state machine with its counter, latched colour and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= 17'd0;
            color_r <= 8'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (fill_start) begin
                        state_r <= FILL;
                        count_r <= 17'd0;
                        color_r <= fill_color;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                FILL: begin
                    // Starts arriving here are dropped: colour and count stay.
                    if (fill_grant) begin
                        count_r <= count_r + 17'd1;
                        if (count_r == LAST_ADDR) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= FILL;
                        end
                    end else begin
                        state_r <= FILL;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign fill_pending = (state_r == FILL);
    assign fill_addr    = count_r;
    assign fill_data    = color_r;
    assign fill_busy    = busy_r;
    assign fill_done    = done_r;

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM port arbiter.
// Shares the single RAM port between scan-out reads (absolute priority),
// CPU pixel writes and the fill engine; the latter two alternate through a
// round-robin pointer that toggles on every CPU or fill grant.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fb_arbiter_if.slave (requester handshakes + RAM port)
// Grants are combinational; the RAM command is registered one cycle later,
// and scan data returns two cycles after its grant.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned FILL_COUNT = FB_SIZE
) (
    input  logic          clk,
    input  logic          rst,
    fb_arbiter_if.slave   bus
);

    logic       fill_pending_s;
    logic       fill_grant_s;
    fb_addr_t   fill_addr_s;
    pixel_t     fill_data_s;
    logic       fill_busy_s;
    logic       fill_done_s;
    requester_t winner_s;

    logic       rr_fill_r;        // 1: fill wins a CPU/fill tie
    fb_addr_t   mem_address_r;
    logic       mem_write_r;
    pixel_t     mem_write_data_r;
    logic [1:0] scan_pipe_r;      // scan grant delayed to match RAM latency

    fb_fill_engine #(
        .FILL_COUNT (FILL_COUNT)
    ) u_fill (
        .clk          (clk),
        .rst          (rst),
        .fill_start   (bus.fill_start),
        .fill_color   (bus.fill_color),
        .fill_grant   (fill_grant_s),
        .fill_pending (fill_pending_s),
        .fill_addr    (fill_addr_s),
        .fill_data    (fill_data_s),
        .fill_busy    (fill_busy_s),
        .fill_done    (fill_done_s)
    );

    // Pick this cycle's single winner: scan first, then CPU/fill round-robin.
    always_comb begin
        winner_s = REQ_NONE;
        if (bus.scan_req) begin
            winner_s = REQ_SCAN;
        end else if (bus.wr_req && fill_pending_s) begin
            winner_s = rr_fill_r ? REQ_FILL : REQ_CPU;
        end else if (bus.wr_req) begin
            winner_s = REQ_CPU;
        end else if (fill_pending_s) begin
            winner_s = REQ_FILL;
        end else begin
            winner_s = REQ_NONE;
        end
    end

    assign bus.scan_grant = (winner_s == REQ_SCAN);
    assign bus.wr_grant   = (winner_s == REQ_CPU);
    assign fill_grant_s   = (winner_s == REQ_FILL);

    // Register the granted RAM command, toggle the pointer, track scan reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_fill_r        <= 1'b0;
            mem_address_r    <= 17'd0;
            mem_write_r      <= 1'b0;
            mem_write_data_r <= 8'd0;
            scan_pipe_r      <= 2'b00;
        end else begin
            scan_pipe_r <= {scan_pipe_r[0], (winner_s == REQ_SCAN)};
            case (winner_s)
                REQ_SCAN: begin
                    mem_address_r <= bus.scan_address;
                    mem_write_r   <= 1'b0;
                end
                REQ_CPU: begin
                    mem_address_r    <= bus.wr_address;
                    mem_write_r      <= 1'b1;
                    mem_write_data_r <= bus.wr_data;
                    rr_fill_r        <= ~rr_fill_r;
                end
                REQ_FILL: begin
                    mem_address_r    <= fill_addr_s;
                    mem_write_r      <= 1'b1;
                    mem_write_data_r <= fill_data_s;
                    rr_fill_r        <= ~rr_fill_r;
                end
                REQ_NONE: begin
                    mem_write_r <= 1'b0;
                end
                default: begin
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_address    = mem_address_r;
    assign bus.mem_write      = mem_write_r;
    assign bus.mem_write_data = mem_write_data_r;
    assign bus.scan_valid     = scan_pipe_r[1];
    // Read data passes straight through, forced to zero when not qualified.
    assign bus.scan_data      = scan_pipe_r[1] ? bus.mem_read_data : 8'd0;
    assign bus.fill_busy      = fill_busy_s;
    assign bus.fill_done      = fill_done_s;

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-clock arbiter that shares the one port of the 320x240 RGB332 framebuffer RAM between three requesters: VGA scan-out reads, CPU pixel writes and a hardware fill (clear-screen) engine. It sits in the GPU clock domain between the CPU's framebuffer store path, the VGA pixel fetch logic and the framebuffer RAM. Scan-out has absolute priority. CPU writes and fill writes share the remaining cycles round-robin, so neither starves.

## Interface
- AddrWidth, 17, framebuffer word address width (76800 pixels)
- DataWidth, 8, pixel width (RGB332)
- FbSize, 76800, number of pixels the fill engine writes
- Clock  in  1  GPU clock; all logic is on the rising edge
- Reset  in  1  synchronous, active-high
- ScanReq  in  1  scan-out read request
- ScanAddress  in  AddrWidth  scan-out read address
- ScanGrant  out  1  combinational; equals ScanReq (scan is always granted)
- ScanValid  out  1  read data valid, 2 cycles after grant
- ScanData  out  DataWidth  read pixel, qualified by ScanValid
- WrReq  in  1  CPU write request; held until granted
- WrAddress  in  AddrWidth  CPU write address
- WrData  in  DataWidth  CPU write pixel
- WrGrant  out  1  combinational; the request is consumed this cycle
- FillStart  in  1  single-cycle pulse that starts a fill
- FillColor  in  DataWidth  fill pixel, sampled when FillStart is accepted
- FillBusy  out  1  high while a fill is in progress
- FillDone  out  1  one-cycle pulse when the fill completes
- MemAddress  out  AddrWidth  registered RAM address
- MemWrite  out  1  registered RAM write enable
- MemWriteData  out  DataWidth  registered RAM write data
- MemReadData  in  DataWidth  RAM read data, 1 cycle after the address is presented

## Operation
- Arbitration runs every cycle, in this priority order:
  - ScanReq wins unconditionally.
  - Otherwise, if only one of WrReq or the fill engine is pending, that one wins.
  - If both are pending, the round-robin pointer decides. The pointer flips after every CPU or fill grant. Its reset value favours the CPU.
- At most one grant per cycle. A cycle with no grant drives MemWrite=0 next cycle; MemAddress holds its previous value.
- A CPU write is granted only when WrGrant=1. WrAddress and WrData must be held stable until then.
- Fill state machine:
  - IDLE: FillStart -> FILL. Latch FillColor and clear the counter to 0.
  - FILL: the fill is pending every cycle. On each fill grant, write the counter value with the latched colour and increment the counter. The grant at count FbSize-1 moves to DONE.
  - DONE: assert FillDone for one cycle, then go to IDLE.
- FillBusy=1 in FILL and DONE.
- FillStart while FillBusy=1 is ignored; colour and counter are unchanged.
- Ordering between CPU and fill writes is grant order. A CPU write to an address the fill has not yet reached will be overwritten by the fill.
- ScanAddress and WrAddress values of FbSize or above are passed through unchanged; range checking is the requester's job.
- Reset mid-fill: the fill is aborted, the state returns to IDLE, the counter goes to 0 and no FillDone pulse is produced.
- Reset values: all outputs are 0, including the registered Mem* outputs and the ScanValid pipeline; the round-robin pointer selects the CPU.

## Timing
- Cycle N: grant, combinational from the request inputs.
- Cycle N+1: Mem* outputs carry the granted command.
- Cycle N+2: MemReadData returns. ScanValid=1 and ScanData=MemReadData, passed through combinationally.
- Scan read latency is exactly 2 cycles, fully pipelined at 1 read per cycle.
- CPU write is visible in RAM at the end of cycle N+1.
- With no scan traffic and no CPU traffic, a fill takes FbSize grants (76800 cycles). FillDone comes 1 cycle after the last fill grant.
- With CPU and fill both continuously requesting, the CPU gets every other free cycle. The maximum CPU wait with no scan traffic is 1 cycle.
- Scan traffic can stall CPU and fill writes indefinitely. This is by design: the scan duty cycle is bounded by blanking.

## Structure
- Shared package fb_pkg holds:
  - FB_WIDTH=320, FB_HEIGHT=240, FB_SIZE=76800
  - fb_addr_t (17-bit) and pixel_t (8-bit RGB332)
  - fill_state_t enum {IDLE, FILL, DONE}
  - requester_t enum {REQ_NONE, REQ_SCAN, REQ_CPU, REQ_FILL}
- One sub-module, fb_fill_engine, contains the fill state machine, counter and latched colour. It exposes a pending/grant pair to the arbiter core.

## Test plan
- Reset then idle -> all outputs 0 and MemWrite never asserted. Reset with FillStart held high -> no fill begins.
- ScanReq on 4 consecutive cycles, addresses 0x00000-0x00003, RAM preloaded with 0x11..0x44 -> ScanValid for 4 cycles starting 2 cycles after the first grant, ScanData 0x11,0x22,0x33,0x44.
- WrReq addr 0x12C00 data 0xE0 together with ScanReq for 3 cycles -> WrGrant=0 for 3 cycles, then 1. MemWrite=1 with addr 0x12C00 and data 0xE0 on the following cycle.
- FillStart colour 0x03, FbSize overridden to 16, WrReq held continuously with changing data -> grants alternate CPU/fill. FillDone pulses once after the 16th fill write. Second FillStart mid-fill is ignored.
- Reset asserted at fill count 5 -> FillBusy=0 next cycle, no FillDone. A new FillStart restarts from address 0.
- FillStart with no other traffic, FbSize=76800 -> FillDone exactly 76801 cycles after FillStart. RAM addresses 0 and 76799 both hold the fill colour.
